mos_xor_cell: RTL and testbench

- Registered, bus-wide XOR cell whose logic follows the team's 6-transistor static XOR topology.
- Per bit: inverter node n_a = ~in1; transmission node n_b = in2 ? in1 : n_a (XNOR); output inverter out1 = ~n_b.
- Used as a clocked datapath primitive in the VLSI cell library. Exposes internal nodes for debug and an optional switching-activity counter for power estimation.

---
 rtl/mos_xor_cell.sv | 91 +++++++++
 tb/tb_mos_xor_cell.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mos_xor_cell.sv
// Registered bus-wide XOR cell modelled on the 6-transistor static XOR: inverter, pass node, output inverter.
// Optional out1 switching-activity counter compiled in with `define MOS_XOR_ACTIVITY_EN.
module mos_xor_cell #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  output logic [WIDTH-1:0] node_a,
  output logic [WIDTH-1:0] node_b,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] act_cnt
);

  logic [WIDTH-1:0] a_comb;
  logic [WIDTH-1:0] b_comb;
  logic [WIDTH-1:0] y_comb;

  // Each bit follows the transistor topology: in2 picks either in1 or its inverted copy.
  // NOTE: every always_comb output gets a default first, so a missed branch cannot infer a latch.
  always_comb begin
    a_comb = '0;
    b_comb = '0;
    y_comb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_comb[i] = ~in1[i];
      b_comb[i] = in2[i] ? in1[i] : a_comb[i];
      y_comb[i] = ~b_comb[i];
    end
  end

  // Reset values match the nodes a settled cell shows when in1 = in2 = 0.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1      <= '0;
      node_a    <= '1;
      node_b    <= '1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        node_a <= a_comb;
        node_b <= b_comb;
        out1   <= y_comb;
      end
    end
  end

`ifdef MOS_XOR_ACTIVITY_EN
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Sum is one bit wider than either operand so overflow is visible and the count can pin at max.
  always_comb begin
    cnt_sum  = SUM_W'(act_cnt) + SUM_W'(popcount(out1 ^ y_comb));
    cnt_next = (|cnt_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt <= '0;
    end else if (cnt_clr) begin
      act_cnt <= '0;
    end else if (in_valid) begin
      act_cnt <= cnt_next;
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign act_cnt        = '0;
`endif

endmodule

// File: tb/tb_mos_xor_cell.sv
// Self-checking bench for mos_xor_cell: table vectors through a scoreboard plus reset/hold/counter sequences.
// Counter expectations follow MOS_XOR_ACTIVITY_EN when it is defined for the build.
module tb_mos_xor_cell;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out1;
  logic             out_valid;
  logic [WIDTH-1:0] node_a;
  logic [WIDTH-1:0] node_b;
  logic             cnt_clr;
  logic [CNT_W-1:0] act_cnt;

  mos_xor_cell #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
    .out1(out1), .out_valid(out_valid), .node_a(node_a), .node_b(node_b),
    .cnt_clr(cnt_clr), .act_cnt(act_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] node_a;
    logic [WIDTH-1:0] node_b;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] node_a;
    logic [WIDTH-1:0] node_b;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_out1;
  int               exp_cnt;
  int               compared   = 0;
  int               mismatched = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out1"},      32'(out1),      32'h00);
    check({tag, " node_a"},    32'(node_a),    32'hFF);
    check({tag, " node_b"},    32'(node_b),    32'hFF);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " act_cnt"},   32'(act_cnt),   32'h0);
  endtask

  // Drives one cycle, updates the reference, then compares after the edge.
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic v,
                      input logic clr, input logic [WIDTH-1:0] eo, input logic [WIDTH-1:0] ena,
                      input logic [WIDTH-1:0] enb);
    exp_t e;
    @(negedge clk);
    in1 = a; in2 = b; in_valid = v; cnt_clr = clr;
    if (v) sb.push_back('{eo, ena, enb});
`ifdef MOS_XOR_ACTIVITY_EN
    if (clr) exp_cnt = 0;
    else if (v) begin
      exp_cnt = exp_cnt + $countones(model_out1 ^ eo);
      if (exp_cnt > (1 << CNT_W) - 1) exp_cnt = (1 << CNT_W) - 1;
    end
`else
    exp_cnt = 0;
`endif
    if (v) model_out1 = eo;
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(v));
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected out_valid", 32'(out_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        check("out1",   32'(out1),   32'(e.out1));
        check("node_a", 32'(node_a), 32'(e.node_a));
        check("node_b", 32'(node_b), 32'(e.node_b));
      end
    end else begin
      check("hold out1", 32'(out1), 32'(model_out1));
    end
    check("act_cnt", 32'(act_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic [WIDTH-1:0] ra, rb;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    tbl[1] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
    tbl[4] = '{8'hA5, 8'h0F, 8'hAA, 8'h5A, 8'h55};
    tbl[5] = '{8'h3C, 8'hC3, 8'hFF, 8'hC3, 8'h00};
    tbl[6] = '{8'h12, 8'h34, 8'h26, 8'hED, 8'hD9};
    tbl[7] = '{8'hA5, 8'h0F, 8'hAA, 8'h5A, 8'h55};

    // Reset with arbitrary inputs and the clock running.
    rst_n = 1'b0; in_valid = 1'b1; in1 = 8'h5A; in2 = 8'hC3; cnt_clr = 1'b0;
    model_out1 = '0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check_reset_state("release");

    // Truth table per slice, several bus patterns, ending with out1 = 0xAA.
    for (int i = 0; i < 8; i++)
      step(tbl[i].in1, tbl[i].in2, 1'b1, 1'b0, tbl[i].out1, tbl[i].node_a, tbl[i].node_b);

    // Hold: an idle edge must not disturb out1 or the nodes.
    step(8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("hold node_a", 32'(node_a), 32'h5A);
    check("hold node_b", 32'(node_b), 32'h55);

    // Asynchronous reset between edges while out1 = 0xAA.
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async");
    sb.delete();
    model_out1 = '0; exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter: results 0x00 -> 0xFF -> 0x00, then clear on a capture.
    step(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
    step(8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
`ifdef MOS_XOR_ACTIVITY_EN
    check("cnt after 8 toggles", 32'(act_cnt), 32'd8);
`endif
    step(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF);
`ifdef MOS_XOR_ACTIVITY_EN
    check("cnt saturated", 32'(act_cnt), 32'd15);
`endif
    step(8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step(8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    check("cnt after clr", 32'(act_cnt), 32'd0);

    // Back-to-back random captures with occasional idle cycles.
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      step(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ra ^ rb, ~ra, ~(ra ^ rb));
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
